debug_trace_buffer: RTL and testbench

Consumer end of the pipeline debug tap. It takes the per-cycle write-back/memory debug signals (PC, WB opcode, register write, memory write), captures qualified records into a circular trace RAM, and applies a PC-match trigger with post-trigger depth. After capture it streams the frozen trace oldest-first to the host over a 32-bit valid/ready word stream. It sits between the core's debug outputs and the host-side debug link.

---
 rtl/debug_trace_buffer_pkg.sv | 24 ++
 rtl/debug_trace_buffer_ram.sv | 19 +
 rtl/debug_trace_buffer.sv | 149 ++++++++++++++
 tb/tb_debug_trace_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_trace_buffer_pkg.sv
// debug_trace_pkg: shared types and record layout for the debug trace buffer.
// DEBUG_TRACE_TIMESTAMP_EN adds a third (timestamp) word to every record.
package debug_trace_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIGGERED = 2'd2, DUMP = 2'd3} trace_state_t;
    typedef struct packed {
        logic [8:0] pc;
        logic [6:0] opcode;
        logic       reg_write;
        logic [4:0] reg_num;
        logic       mem_wr;
        logic [8:0] mem_addr;
    } trace_rec_t;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    localparam int WORDS_PER_REC = 3;
`else
    localparam int WORDS_PER_REC = 2;
`endif
    localparam int W0_MEM_ADDR  = 0;
    localparam int W0_MEM_WR    = 9;
    localparam int W0_REG_NUM   = 10;
    localparam int W0_REG_WRITE = 15;
    localparam int W0_OPCODE    = 16;
    localparam int W0_PC        = 23;
endpackage

// File: rtl/debug_trace_buffer_ram.sv
// trace_ram: simple dual-port record store, synchronous write, registered read.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: circular trace capture with PC trigger and oldest-first word stream.
// Define DEBUG_TRACE_TIMESTAMP_EN to append a 16-bit timestamp word to each record.
module debug_trace_buffer
    import debug_trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int PC_W      = 9,
    parameter int DATA_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     trig_en,
    input  logic [PC_W-1:0]          trig_pc,
    input  logic                     rec_valid,
    input  logic [PC_W-1:0]          pc,
    input  logic [6:0]               opcode_wb,
    input  logic                     reg_write,
    input  logic [4:0]               reg_num,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     mem_wr,
    input  logic [PC_W-1:0]          mem_addr,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_last,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   rec_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = WORDS_PER_REC * DATA_W;

    trace_state_t     state, state_d;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_d, rd_ptr, raddr, post_cnt;
    logic [CNT_W-1:0] rec_count_d, dump_rem;
    logic             wrapped, wrapped_d, primed, capture, store, trig_hit, xfer, last_word;
    logic [1:0]       word_sel;
    trace_rec_t       w0;
    logic [REC_W-1:0] wdata, rdata;

    assign state_o   = state;
    assign capture   = state == ARMED || state == TRIGGERED;
    assign store     = capture && rec_valid;
    assign trig_hit  = trig_en && rec_valid && pc == trig_pc;
    assign xfer      = rd_valid && rd_ready;
    assign last_word = word_sel == 2'(WORDS_PER_REC - 1);
    assign rd_last   = rd_valid && last_word && dump_rem == CNT_W'(1);
    assign rd_data   = rd_valid ? rdata[int'(word_sel)*DATA_W +: DATA_W] : '0;
    // Look ahead on the record advance so the registered read is ready with no bubble.
    assign raddr     = (xfer && last_word) ? rd_ptr + 1'b1 : rd_ptr;
    assign wr_ptr_d    = store ? wr_ptr + 1'b1 : wr_ptr;
    assign wrapped_d   = wrapped || (store && wr_ptr == PTR_W'(DEPTH - 1));
    assign rec_count_d = (store && rec_count != CNT_W'(DEPTH)) ? rec_count + 1'b1 : rec_count;

    always_comb begin
        w0 = '0;
        w0[W0_PC +: 9]       = pc[8:0];
        w0[W0_OPCODE +: 7]   = opcode_wb;
        w0[W0_REG_WRITE]     = reg_write;
        w0[W0_REG_NUM +: 5]  = reg_num;
        w0[W0_MEM_WR]        = mem_wr;
        w0[W0_MEM_ADDR +: 9] = mem_addr[8:0];
    end

`ifdef DEBUG_TRACE_TIMESTAMP_EN
    logic [15:0] ts;

    always_ff @(posedge clk) begin
        if (reset) ts <= '0;
        else ts <= (state == IDLE && arm) ? '0 : ts + 1'b1;
    end

    assign wdata = {DATA_W'(ts), wb_data, DATA_W'(w0)};
`else
    assign wdata = {wb_data, DATA_W'(w0)};
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:      state_d = arm ? ARMED : IDLE;
            ARMED:     state_d = (stop || (trig_hit && POST_TRIG == 0)) ? DUMP : trig_hit ? TRIGGERED : ARMED;
            TRIGGERED: state_d = (stop || (rec_valid && post_cnt == PTR_W'(1))) ? DUMP : TRIGGERED;
            DUMP:      state_d = ((!primed && dump_rem == '0) || (xfer && rd_last)) ? IDLE : DUMP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rec_count <= '0;
            wrapped   <= 1'b0;
            post_cnt  <= '0;
            rd_ptr    <= '0;
            dump_rem  <= '0;
            word_sel  <= '0;
            primed    <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            if (state == IDLE && arm) begin
                wr_ptr    <= '0;
                rec_count <= '0;
                wrapped   <= 1'b0;
                post_cnt  <= '0;
            end else begin
                wr_ptr    <= wr_ptr_d;
                rec_count <= rec_count_d;
                wrapped   <= wrapped_d;
            end
            if (state == ARMED && trig_hit) post_cnt <= PTR_W'(POST_TRIG);
            else if (state == TRIGGERED && rec_valid) post_cnt <= post_cnt - 1'b1;
            if (capture && state_d == DUMP) begin
                rd_ptr   <= wrapped_d ? wr_ptr_d : '0;
                dump_rem <= rec_count_d;
                word_sel <= '0;
                primed   <= 1'b0;
            end else if (state == DUMP) begin
                if (!primed) begin
                    primed   <= 1'b1;
                    rd_valid <= dump_rem != '0;
                end else if (xfer) begin
                    if (rd_last) rd_valid <= 1'b0;
                    else if (last_word) begin
                        word_sel <= '0;
                        rd_ptr   <= rd_ptr + 1'b1;
                        dump_rem <= dump_rem - 1'b1;
                    end else word_sel <= word_sel + 1'b1;
                end
            end
        end
    end

    trace_ram #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_ram (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb_debug_trace_buffer: directed self-checking bench for debug_trace_buffer (default build).
module tb_debug_trace_buffer;
    logic        clk = 0, reset = 1, arm = 0, stop = 0, trig_en = 0, rec_valid = 0;
    logic [8:0]  trig_pc = '0, pc = '0, mem_addr = '0;
    logic [6:0]  opcode_wb = '0;
    logic        reg_write = 0, mem_wr = 0, rd_ready = 0;
    logic [4:0]  reg_num = '0;
    logic [31:0] wb_data = '0;
    logic        rd_valid, rd_last;
    logic [31:0] rd_data;
    logic [1:0]  state_o;
    logic [4:0]  rec_count;

    int          total = 0, passed = 0;
    logic [31:0] got[$];
    logic [8:0]  exp_pcs[$];
    int          last_idx, last_cnt;

    debug_trace_buffer dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
        .rec_valid(rec_valid), .pc(pc), .opcode_wb(opcode_wb), .reg_write(reg_write),
        .reg_num(reg_num), .wb_data(wb_data), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .state_o(state_o), .rec_count(rec_count)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] f_op(input logic [8:0] p);
        return p[6:0] ^ 7'h33;
    endfunction

    function automatic logic [4:0] f_rn(input logic [8:0] p);
        return p[4:0] + 5'd1;
    endfunction

    function automatic logic [8:0] f_ma(input logic [8:0] p);
        return p + 9'd3;
    endfunction

    function automatic logic [31:0] f_w0(input logic [8:0] p);
        return {p, f_op(p), p[0], f_rn(p), p[1], f_ma(p)};
    endfunction

    function automatic logic [31:0] f_w1(input logic [8:0] p);
        return 32'hA500_0000 | {23'b0, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [8:0] p);
        @(negedge clk);
        arm = 0; stop = 0; rec_valid = 1; pc = p;
        opcode_wb = f_op(p); reg_write = p[0]; reg_num = f_rn(p);
        mem_wr = p[1]; mem_addr = f_ma(p); wb_data = f_w1(p);
    endtask

    task automatic pulse_arm();
        @(negedge clk);
        rec_valid = 0; arm = 1;
        @(negedge clk);
        arm = 0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        rec_valid = 0; stop = 1;
        @(negedge clk);
        stop = 0;
    endtask

    task automatic collect(input string tag, input int max_words, input bit toggle);
        bit          done = 0, prev_stall = 0;
        logic [31:0] prev_data = '0;
        int          c;
        got.delete();
        last_idx = -1;
        last_cnt = 0;
        for (c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            rd_ready = toggle ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            if (rd_valid) begin
                if (prev_stall) chk({tag, " stall hold"}, rd_data, prev_data);
                if (rd_ready) begin
                    got.push_back(rd_data);
                    if (rd_last) begin
                        last_cnt++;
                        last_idx = got.size() - 1;
                        done = 1;
                    end
                    if (got.size() == max_words) done = 1;
                end
                prev_stall = !rd_ready;
                prev_data  = rd_data;
            end
        end
        chk({tag, " dump finished"}, 32'(done), 32'd1);
    endtask

    task automatic verify(input string tag);
        int          mism = 0;
        logic [31:0] e;
        for (int k = 0; k < got.size(); k++) begin
            if (k / 2 < exp_pcs.size()) begin
                e = (k % 2 == 0) ? f_w0(exp_pcs[k/2]) : f_w1(exp_pcs[k/2]);
                if (got[k] !== e) mism++;
            end else mism++;
        end
        chk({tag, " nwords"}, got.size(), 2 * exp_pcs.size());
        chk({tag, " word mismatches"}, mism, 0);
        chk({tag, " last index"}, last_idx, got.size() - 1);
        chk({tag, " last count"}, last_cnt, 1);
    endtask

    task automatic end_of_dump(input string tag);
        @(negedge clk);
        chk({tag, " rd_valid after last"}, 32'(rd_valid), 0);
        chk({tag, " state after last"}, 32'(state_o), 0);
        rd_ready = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset state", 32'(state_o), 0);
        chk("reset rd_valid", 32'(rd_valid), 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset rd_last", 32'(rd_last), 0);
        chk("reset rec_count", 32'(rec_count), 0);
        reset = 0;

        // 1: five records, stop, 10 words
        pulse_arm();
        chk("t1 armed", 32'(state_o), 1);
        for (int i = 0; i < 5; i++) send(9'h010 + 9'(i));
        pulse_stop();
        chk("t1 state dump", 32'(state_o), 3);
        chk("t1 rec_count", 32'(rec_count), 5);
        exp_pcs = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014};
        collect("t1", 100, 0);
        verify("t1");
        chk("t1 first word", got[0], f_w0(9'h010));
        chk("t1 final word", got[got.size()-1], f_w1(9'h014));
        end_of_dump("t1");

        // 2: trigger at index 20 with 8 post-trigger records
        trig_en = 1; trig_pc = 9'h040;
        pulse_arm();
        for (int i = 1; i <= 30; i++) begin
            send(i == 20 ? 9'h040 : 9'(i));
            if (i == 21) chk("t2 triggered", 32'(state_o), 2);
            if (i == 29) chk("t2 dump after post", 32'(state_o), 3);
        end
        @(negedge clk);
        rec_valid = 0;
        trig_en = 0;
        chk("t2 rec_count", 32'(rec_count), 16);
        exp_pcs.delete();
        for (int i = 13; i <= 28; i++) exp_pcs.push_back(i == 20 ? 9'h040 : 9'(i));
        collect("t2", 100, 0);
        verify("t2");
        chk("t2 trigger word", got[2*7], f_w0(9'h040));
        end_of_dump("t2");

        // 3: wrap without trigger, 20 records
        pulse_arm();
        for (int i = 0; i < 20; i++) send(9'h080 + 9'(i));
        pulse_stop();
        chk("t3 rec_count saturated", 32'(rec_count), 16);
        exp_pcs.delete();
        for (int i = 4; i < 20; i++) exp_pcs.push_back(9'h080 + 9'(i));
        collect("t3", 100, 0);
        verify("t3");
        end_of_dump("t3");

        // 4: back-pressure pattern 1-0-0-1
        pulse_arm();
        for (int i = 0; i < 4; i++) send(9'h150 + 9'(i * 7));
        pulse_stop();
        exp_pcs = '{9'h150, 9'h157, 9'h15E, 9'h165};
        collect("t4", 100, 1);
        verify("t4");
        end_of_dump("t4");

        // 5: empty capture
        pulse_arm();
        pulse_stop();
        chk("t5 state dump", 32'(state_o), 3);
        chk("t5 rd_valid entry", 32'(rd_valid), 0);
        rd_ready = 1;
        @(negedge clk);
        chk("t5 idle after 1", 32'(state_o), 0);
        chk("t5 rd_valid c1", 32'(rd_valid), 0);
        @(negedge clk);
        chk("t5 rd_valid c2", 32'(rd_valid), 0);
        rd_ready = 0;

        // 6: reset mid-dump, then fresh capture
        pulse_arm();
        for (int i = 0; i < 6; i++) send(9'h0C0 + 9'(i));
        pulse_stop();
        collect("t6a", 3, 0);
        chk("t6 three words", got.size(), 3);
        reset = 1;
        @(negedge clk);
        chk("t6 rd_valid after reset", 32'(rd_valid), 0);
        chk("t6 state after reset", 32'(state_o), 0);
        chk("t6 rec_count after reset", 32'(rec_count), 0);
        reset = 0;
        rd_ready = 0;
        pulse_arm();
        send(9'h1A0);
        send(9'h1A1);
        pulse_stop();
        exp_pcs = '{9'h1A0, 9'h1A1};
        collect("t6b", 100, 0);
        verify("t6b");
        end_of_dump("t6b");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
